// File: rtl/deadband_gen_pkg.sv
// PKG_pwm: shared PWM-path types for the dead-band generator (channel states,
// default dead-time width, enable encodings).
package PKG_pwm;
    localparam int DT_WIDTH_DEF = 10;

    typedef enum logic [2:0] {OFF, DT_A, ON_A, DT_B, ON_B} dt_state_t;

    typedef enum logic {PWM_DIS = 1'b0, PWM_ENA = 1'b1} _pwm_onoff;
    typedef enum logic {DT_DIS = 1'b0, DT_ENA = 1'b1} _dt_onoff;
endpackage

// File: rtl/deadband_gen_if.sv
// deadband_gen_if: per-channel PWM inputs, dead-time/polarity controls and gate outputs.
interface deadband_gen_if
    import PKG_pwm::*;
#(
    parameter int N_CH     = 8,
    parameter int DT_WIDTH = DT_WIDTH_DEF
);
    logic [N_CH-1:0]               pwm_in;
    logic [N_CH-1:0][DT_WIDTH-1:0] dtime_a;
    logic [N_CH-1:0][DT_WIDTH-1:0] dtime_b;
    logic [N_CH-1:0]               logic_a;
    logic [N_CH-1:0]               logic_b;
    logic [N_CH-1:0]               pwm_en;
    logic [N_CH-1:0]               dt_en;
    logic                          update;
    logic [N_CH-1:0]               pwm_a;
    logic [N_CH-1:0]               pwm_b;
    logic [N_CH-1:0]               dt_busy;

    modport master (
        output pwm_in, dtime_a, dtime_b, logic_a, logic_b, pwm_en, dt_en, update,
        input  pwm_a, pwm_b, dt_busy
    );
    modport slave (
        input  pwm_in, dtime_a, dtime_b, logic_a, logic_b, pwm_en, dt_en, update,
        output pwm_a, pwm_b, dt_busy
    );
endinterface

// File: rtl/deadband_gen_ch.sv
// deadband_ch: one complementary A/B leg with independent rising/falling dead times.
// DEADBAND_SHADOW_EN: dead times come from shadow flops loaded on update.
module deadband_ch
    import PKG_pwm::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dtime_a,
    input  logic [DT_WIDTH-1:0] dtime_b,
    input  logic                logic_a,
    input  logic                logic_b,
    input  logic                pwm_en,
    input  logic                dt_en,
    input  logic                update,
    output logic                pwm_a,
    output logic                pwm_b,
    output logic                dt_busy
);
    dt_state_t           state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DT_WIDTH-1:0] d_a, d_b;

`ifdef DEADBAND_SHADOW_EN
    logic [DT_WIDTH-1:0] sha_q, sha_d, shb_q, shb_d;

    always_comb begin
        sha_d = update ? dtime_a : sha_q;
        shb_d = update ? dtime_b : shb_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sha_q <= '0;
            shb_q <= '0;
        end else begin
            sha_q <= sha_d;
            shb_q <= shb_d;
        end
    end

    assign d_a = sha_q;
    assign d_b = shb_q;
`else
    logic unused_update;
    assign unused_update = update;
    assign d_a = dtime_a;
    assign d_b = dtime_b;
`endif

    // A reversal from any state other than the matching ON restarts the count toward the new side.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (pwm_en == PWM_DIS) begin
            state_d = OFF;
            cnt_d   = '0;
        end else if (dt_en == DT_DIS) begin
            state_d = pwm_in ? ON_A : OFF;
            cnt_d   = '0;
        end else if (pwm_in) begin
            if (state_q == DT_A) begin
                state_d = (cnt_q >= d_a) ? ON_A : DT_A;
                cnt_d   = (cnt_q >= d_a) ? '0 : cnt_q + 1'b1;
            end else if (state_q != ON_A) begin
                state_d = (d_a == '0) ? ON_A : DT_A;
                cnt_d   = (d_a == '0) ? '0 : DT_WIDTH'(1);
            end
        end else begin
            if (state_q == DT_B) begin
                state_d = (cnt_q >= d_b) ? ON_B : DT_B;
                cnt_d   = (cnt_q >= d_b) ? '0 : cnt_q + 1'b1;
            end else if (state_q != ON_B) begin
                state_d = (d_b == '0) ? ON_B : DT_B;
                cnt_d   = (d_b == '0) ? '0 : DT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pwm_a   = ((state_q == ON_A) ^ ~logic_a) & pwm_en;
    assign pwm_b   = ((state_q == ON_B) ^ ~logic_b) & pwm_en;
    assign dt_busy = (state_q == DT_A) || (state_q == DT_B);
endmodule

// File: rtl/deadband_gen.sv
// deadband_gen: N_CH independent complementary dead-band channels.
// DEADBAND_SHADOW_EN: dead times are shadowed and applied on update.
module deadband_gen
    import PKG_pwm::*;
#(
    parameter int N_CH     = 8,
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    deadband_gen_if.slave  bus
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        deadband_ch #(.DT_WIDTH(DT_WIDTH)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .pwm_in  (bus.pwm_in[i]),
            .dtime_a (bus.dtime_a[i]),
            .dtime_b (bus.dtime_b[i]),
            .logic_a (bus.logic_a[i]),
            .logic_b (bus.logic_b[i]),
            .pwm_en  (bus.pwm_en[i]),
            .dt_en   (bus.dt_en[i]),
            .update  (bus.update),
            .pwm_a   (bus.pwm_a[i]),
            .pwm_b   (bus.pwm_b[i]),
            .dt_busy (bus.dt_busy[i])
        );
    end
endmodule
